// File: rtl/sm_regdump_uart_pkg.sv
// Shared FSM encoding, record framing constants and the record byte selector
// for the register-dump UART.
package sm_regdump_uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        SEND   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int RECORD_BYTES    = 5;
    localparam int UART_FRAME_BITS = 10;

    // Record bytes 1..4 carry the snapshot MSB first; byte 0 is the address.
    function automatic logic [7:0] recordDataByte(input logic [31:0] snap, input logic [2:0] idx);
        case (idx)
            3'd1:    recordDataByte = snap[31:24];
            3'd2:    recordDataByte = snap[23:16];
            3'd3:    recordDataByte = snap[15:8];
            default: recordDataByte = snap[7:0];
        endcase
    endfunction

endpackage

// File: rtl/sm_regdump_uart_if.sv
// Debug register port plus UART/status lines of the register dumper.
// master = dump engine (drives regAddr, tx, status); slave = core/board side.
interface sm_regdump_uart_if;
    logic        start;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        tx;
    logic        busy;
    logic        done;

    modport master (input start, input regData, output regAddr, output tx, output busy, output done);
    modport slave  (output start, output regData, input regAddr, input tx, input busy, input done);
endinterface

// File: rtl/sm_uart_tx.sv
// 8N1 byte serialiser, CLK_DIV cycles per bit, 10*CLK_DIV cycles per frame.
// ready is high when idle and on the final stop-bit cycle, so frames can abut.
module sm_uart_tx
    import sm_regdump_uart_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);
    localparam int                BAUD_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [3:0]        BIT_LAST  = 4'(UART_FRAME_BITS - 1);

    logic              active;
    logic [BAUD_W-1:0] baudCnt;
    logic [3:0]        bitCnt;
    logic [8:0]        shiftReg;
    logic              frameEnd;

    assign frameEnd = active && (baudCnt == BAUD_LAST) && (bitCnt == BIT_LAST);
    assign ready    = !active || frameEnd;

    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= 1'b0;
            baudCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= '1;
            tx       <= 1'b1;
        end else if (ready && valid) begin
            // Start bit goes out now; data bits follow with the stop bit behind them.
            active   <= 1'b1;
            baudCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= {1'b1, data};
            tx       <= 1'b0;
        end else if (frameEnd) begin
            active  <= 1'b0;
            baudCnt <= '0;
            bitCnt  <= '0;
            tx      <= 1'b1;
        end else if (active) begin
            if (baudCnt == BAUD_LAST) begin
                baudCnt  <= '0;
                bitCnt   <= bitCnt + 4'd1;
                tx       <= shiftReg[0];
                shiftReg <= {1'b1, shiftReg[8:1]};
            end else begin
                baudCnt <= baudCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm_regdump_uart.sv
// Dumps registers FIRST_REG..LAST_REG as 5-byte UART records (addr, data MSB first),
// 1 + 50*CLK_DIV cycles per record; start is ignored while a dump is in progress.
module sm_regdump_uart
    import sm_regdump_uart_pkg::*;
#(
    parameter int CLK_DIV   = 434,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input logic                 clk,
    input logic                 rst,
    sm_regdump_uart_if.master   dbg
);
    localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
    localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);
    localparam logic [2:0] ALL_LOADED = 3'(RECORD_BYTES);

    state_t      state, stateNext;
    logic [4:0]  regAddr;
    logic [31:0] snapshot;
    logic [2:0]  byteIdx;
    logic        busy, done, busyNext, doneNext;
    logic        txValid, txReady, txLine;
    logic [7:0]  txData;
    logic        recordEnd;

    // Last byte already handed over and its stop bit is on its final cycle.
    assign recordEnd = (state == SEND) && (byteIdx == ALL_LOADED) && txReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            regAddr  <= FIRST_ADDR;
            snapshot <= '0;
            byteIdx  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= stateNext;
            busy  <= busyNext;
            done  <= doneNext;
            if (state == IDLE && dbg.start) begin
                regAddr <= FIRST_ADDR;
            end else if (recordEnd && regAddr != LAST_ADDR) begin
                regAddr <= regAddr + 5'd1;
            end
            if (state == SAMPLE) begin
                snapshot <= dbg.regData;
                byteIdx  <= 3'd1;
            end else if (state == SEND && txValid && txReady) begin
                byteIdx <= byteIdx + 3'd1;
            end
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (dbg.start) stateNext = SAMPLE;
            SAMPLE:  stateNext = SEND;
            SEND:    if (recordEnd) stateNext = (regAddr == LAST_ADDR) ? DONE : SAMPLE;
            default: stateNext = IDLE;
        endcase
    end

    // Address byte is loaded straight from regAddr in SAMPLE; data bytes come from the snapshot.
    always_comb begin
        txValid  = 1'b0;
        txData   = {3'b000, regAddr};
        busyNext = (stateNext == SAMPLE) || (stateNext == SEND);
        doneNext = (stateNext == DONE);
        if (state == SAMPLE) begin
            txValid = 1'b1;
        end else if (state == SEND && byteIdx != ALL_LOADED) begin
            txValid = 1'b1;
            txData  = recordDataByte(snapshot, byteIdx);
        end
    end

    sm_uart_tx #(.CLK_DIV(CLK_DIV)) uTx (
        .clk   (clk),
        .rst   (rst),
        .data  (txData),
        .valid (txValid),
        .ready (txReady),
        .tx    (txLine)
    );

    assign dbg.regAddr = regAddr;
    assign dbg.tx      = txLine;
    assign dbg.busy    = busy;
    assign dbg.done    = done;

endmodule

// File: tb/tb_sm_regdump_uart.sv
// Bench for sm_regdump_uart: single-register vectors on one instance, full dumps,
// snapshot hold, ignored starts and mid-dump reset on a second instance.
module tb_sm_regdump_uart;
    localparam int DIV      = 4;
    localparam int BYTE_CYC = 10 * DIV;
    localparam int REC_CYC  = 1 + 50 * DIV;

    typedef struct {
        logic [31:0] data;
        logic [39:0] expBytes;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nChecks = 0;
    int   nPass = 0;
    int   donesB = 0;

    logic [31:0] dataA = '0;
    logic        corruptEn = 1'b0;
    logic [4:0]  lastAddr = '0;
    int          addrAge = 0;
    vec_t        vecs[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sm_regdump_uart_if ifA ();
    sm_regdump_uart_if ifB ();

    sm_regdump_uart #(.CLK_DIV(DIV), .FIRST_REG(5), .LAST_REG(5)) dutA (
        .clk (clk), .rst (rst), .dbg (ifA)
    );
    sm_regdump_uart #(.CLK_DIV(DIV), .FIRST_REG(0), .LAST_REG(31)) dutB (
        .clk (clk), .rst (rst), .dbg (ifB)
    );

    // Core model for B: reg n reads n*0x01010101; record 2 data is zeroed once past its SAMPLE cycle.
    always @(negedge clk) begin
        addrAge  <= (ifB.regAddr != lastAddr) ? 0 : addrAge + 1;
        lastAddr <= ifB.regAddr;
        if (ifB.done) donesB <= donesB + 1;
    end
    assign ifB.regData = (corruptEn && ifB.regAddr == 5'd2 && lastAddr == 5'd2 && addrAge >= 1)
                         ? 32'h0 : 32'(ifB.regAddr) * 32'h01010101;
    assign ifA.regData = dataA;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    function automatic logic txOf(input bit useB);
        return useB ? ifB.tx : ifA.tx;
    endfunction

    task automatic pulseStart(input bit useB);
        @(negedge clk);
        if (useB) ifB.start = 1'b1; else ifA.start = 1'b1;
        @(negedge clk);
        if (useB) ifB.start = 1'b0; else ifA.start = 1'b0;
    endtask

    // Finds the first cycle of a start bit, samples each data bit once per bit period,
    // returns in the first stop-bit cycle.
    task automatic rxByte(input bit useB, output logic [7:0] b, output int startCyc, output bit ok);
        bit found;
        found = 1'b0; b = '0; ok = 1'b0; startCyc = -1;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (txOf(useB) == 1'b0) found = 1'b1;
        end
        if (found) begin
            startCyc = cyc;
            for (int j = 0; j < 8; j++) begin
                repeat (DIV) @(negedge clk);
                b[j] = txOf(useB);
            end
            repeat (DIV) @(negedge clk);
            ok = (txOf(useB) == 1'b1);
        end
    endtask

    task automatic waitDone(input bit useB, output int doneCyc);
        doneCyc = -1;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if ((useB ? ifB.done : ifA.done) == 1'b1) begin
                doneCyc = cyc;
                break;
            end
        end
    endtask

    task automatic idleTest();
        int badTx, badBusy, badDone, badAddr;
        badTx = 0; badBusy = 0; badDone = 0; badAddr = 0;
        repeat (100) begin
            @(negedge clk);
            if (ifB.tx !== 1'b1 || ifA.tx !== 1'b1) badTx++;
            if (ifB.busy !== 1'b0 || ifA.busy !== 1'b0) badBusy++;
            if (ifB.done !== 1'b0 || ifA.done !== 1'b0) badDone++;
            if (ifB.regAddr !== 5'd0 || ifA.regAddr !== 5'd5) badAddr++;
        end
        check("idle_tx_bad_cycles", 32'(badTx), 0);
        check("idle_busy_bad_cycles", 32'(badBusy), 0);
        check("idle_done_bad_cycles", 32'(badDone), 0);
        check("idle_regaddr_bad_cycles", 32'(badAddr), 0);
    endtask

    task automatic runVectors();
        for (int i = 0; i < 4; i++) begin
            int busyCyc, doneCyc, sc, prevSc, gapErr, frameErr;
            logic [7:0] b;
            bit ok;
            gapErr = 0; frameErr = 0; prevSc = 0;
            dataA = vecs[i].data;
            pulseStart(1'b0);
            busyCyc = cyc;
            check($sformatf("vec%0d_busy_rise", i), 32'(ifA.busy), 1);
            for (int k = 0; k < 5; k++) begin
                rxByte(1'b0, b, sc, ok);
                if (!ok) frameErr++;
                if (k > 0 && sc - prevSc != BYTE_CYC) gapErr++;
                prevSc = sc;
                check($sformatf("vec%0d_byte%0d", i, k), 32'(b), 32'(vecs[i].expBytes[39-8*k -: 8]));
            end
            check($sformatf("vec%0d_byte_spacing_errs", i), 32'(gapErr), 0);
            check($sformatf("vec%0d_stop_bit_errs", i), 32'(frameErr), 0);
            waitDone(1'b0, doneCyc);
            check($sformatf("vec%0d_done_latency", i), 32'(doneCyc - busyCyc), 32'(REC_CYC));
            check($sformatf("vec%0d_busy_at_done", i), 32'(ifA.busy), 0);
            @(negedge clk);
            check($sformatf("vec%0d_done_one_cycle", i), 32'(ifA.done), 0);
        end
    endtask

    task automatic fullDump(input bit withCorrupt, input bit withNoise, input string tag);
        int busyCyc, doneCyc, d0, byteErr, gapErr, frameErr;
        logic [31:0] rec2;
        byteErr = 0; gapErr = 0; frameErr = 0; rec2 = '0; doneCyc = -1;
        d0 = donesB;
        corruptEn = withCorrupt;
        pulseStart(1'b1);
        busyCyc = cyc;
        check({tag, "_busy_rise"}, 32'(ifB.busy), 1);
        check({tag, "_regaddr_first"}, 32'(ifB.regAddr), 0);
        fork
            begin
                int sc, prevSc;
                logic [7:0] b;
                bit ok;
                prevSc = 0;
                for (int r = 0; r < 32; r++) begin
                    for (int k = 0; k < 5; k++) begin
                        rxByte(1'b1, b, sc, ok);
                        if (!ok) frameErr++;
                        if (b !== 8'(r)) byteErr++;
                        if (k > 0 && sc - prevSc != BYTE_CYC) gapErr++;
                        if (k == 0 && r > 0 && sc - prevSc != BYTE_CYC + 1) gapErr++;
                        if (r == 2 && k > 0) rec2 = {rec2[23:0], b};
                        prevSc = sc;
                    end
                end
                waitDone(1'b1, doneCyc);
            end
            begin
                if (withNoise) begin
                    for (int n = 0; n < 5; n++) begin
                        repeat ($urandom_range(1000, 100)) @(negedge clk);
                        if (ifB.busy) begin
                            ifB.start = 1'b1;
                            @(negedge clk);
                            ifB.start = 1'b0;
                        end
                    end
                    // A start landing on the DONE cycle must not launch a new dump.
                    for (int i = 0; i < 8000; i++) begin
                        @(negedge clk);
                        if (ifB.done) break;
                    end
                    ifB.start = 1'b1;
                    @(negedge clk);
                    ifB.start = 1'b0;
                end
            end
        join
        corruptEn = 1'b0;
        check({tag, "_byte_errs"}, 32'(byteErr), 0);
        check({tag, "_spacing_errs"}, 32'(gapErr), 0);
        check({tag, "_stop_bit_errs"}, 32'(frameErr), 0);
        check({tag, "_rec2_data"}, rec2, 32'h02020202);
        check({tag, "_done_latency"}, 32'(doneCyc - busyCyc), 32'(32 * REC_CYC));
        repeat (5) @(negedge clk);
        check({tag, "_busy_after_done"}, 32'(ifB.busy), 0);
        check({tag, "_done_pulses"}, 32'(donesB - d0), 1);
        check({tag, "_regaddr_held"}, 32'(ifB.regAddr), 31);
    endtask

    task automatic resetTest();
        logic [7:0] b;
        int sc, d0, badIdle;
        bit ok;
        pulseStart(1'b1);
        for (int n = 0; n < 16; n++) rxByte(1'b1, b, sc, ok);
        repeat (5) @(negedge clk);
        check("rst_pre_busy", 32'(ifB.busy), 1);
        check("rst_pre_tx_in_start_bit", 32'(ifB.tx), 0);
        check("rst_pre_regaddr", 32'(ifB.regAddr), 3);
        d0 = donesB;
        rst = 1'b1;
        @(negedge clk);
        check("rst_tx", 32'(ifB.tx), 1);
        check("rst_busy", 32'(ifB.busy), 0);
        check("rst_done", 32'(ifB.done), 0);
        check("rst_regaddr", 32'(ifB.regAddr), 0);
        rst = 1'b0;
        badIdle = 0;
        repeat (60) begin
            @(negedge clk);
            if (ifB.tx !== 1'b1 || ifB.busy !== 1'b0) badIdle++;
        end
        check("rst_quiet_bad_cycles", 32'(badIdle), 0);
        check("rst_no_done", 32'(donesB - d0), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'hDEADBEEF, 40'h05_DE_AD_BE_EF};
        vecs[1] = '{32'h00000000, 40'h05_00_00_00_00};
        vecs[2] = '{32'hFFFFFFFF, 40'h05_FF_FF_FF_FF};
        vecs[3] = '{32'h80A5_3C01, 40'h05_80_A5_3C_01};
        ifA.start = 1'b0;
        ifB.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idleTest();
        runVectors();
        fullDump(1'b1, 1'b1, "dump1");
        resetTest();
        fullDump(1'b0, 1'b0, "dump2");
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
